vita49_pkt_arb: RTL and testbench
=================================

# vita49_pkt_arb

Packet-granular round-robin arbiter that merges up to eight VITA-49 payload streams (one per `vita49_unpack` instance) onto a single AXI-Stream master toward the DMA/FIFO. A grant is held for exactly one whole packet, from the first beat through the beat with TLAST; no packet is ever interleaved or truncated. Processor control and status use the same 32-bit ctrl/status register convention as the unpack blocks.

## Interface
Parameters:
- `N_CH`, default 4: number of slave streams; legal range 2..8.
- `GW`, default `$clog2(N_CH)`: width of the grant index.

Ports (one clock; reset is synchronous and active-low):
- `AXIS_ACLK` in 1: the single clock.
- `AXIS_ARESETN` in 1: synchronous reset, active-low.
- `S_AXIS_TDATA` in N_CH*32: slave data; channel k occupies bits [32k+31:32k].
- `S_AXIS_TVALID` in N_CH: per-channel valid.
- `S_AXIS_TLAST` in N_CH: per-channel last.
- `S_AXIS_TREADY` out N_CH: per-channel ready.
- `M_AXIS_TDATA` out 32: merged data.
- `M_AXIS_TVALID` out 1: merged valid.
- `M_AXIS_TLAST` out 1: merged last.
- `M_AXIS_TREADY` in 1: downstream ready.
- `ctrl` in 32: control bits.
  - bit0 `enable`.
  - bit1 `clr_cnt`.
  - bits[8+N_CH-1:8] `ch_mask`; 1 means the channel is eligible.
- `status` out 32: status bits.
  - [31:30] state.
  - [29] enable.
  - [18:16] last_grant.
  - [10:8] grant.
  - [7:0] per-channel TVALID, zero-padded.
- `pkt_fwd` out 32: count of forwarded packets.
- `beat_fwd` out 32: count of forwarded payload beats (tag words excluded).

## Operation
- State machine `A_IDLE` → (`A_TAG`) → `A_DATA` → `A_IDLE`.
- **A_IDLE**
  - Every `S_AXIS_TREADY` is 0 and `M_AXIS_TVALID` is 0.
  - The request vector is `S_AXIS_TVALID & ch_mask`.
  - If `enable` is set and any request is active: pick the first active request searching from `last_grant+1` upward, wrapping modulo N_CH.
  - Register the pick as `grant`, then go to `A_TAG` if tagging is compiled in, otherwise `A_DATA`.
- **A_DATA**
  - `M_AXIS_TDATA`, `M_AXIS_TVALID` and `M_AXIS_TLAST` are driven by the granted channel's signals through a combinational mux.
  - `S_AXIS_TREADY[grant]` equals `M_AXIS_TREADY`; every other TREADY is 0.
  - On each m_xfr (TVALID & TREADY), `beat_fwd` increments.
  - On an m_xfr with TLAST:
    - `pkt_fwd` increments;
    - `last_grant` is set to `grant`;
    - the per-channel sequence counter `seq[grant]` increments;
    - the next state is `A_IDLE`.
- `enable` and `ch_mask` are sampled only in `A_IDLE`. Deasserting either mid-packet lets the current packet complete.
- `clr_cnt` is a level. While it is high, `pkt_fwd`, `beat_fwd` and every `seq` hold 0. Arbitration and data flow are unaffected.
- Counter arithmetic: `pkt_fwd` and `beat_fwd` are 32-bit and `seq` is 16-bit. All of them wrap modulo 2^n without saturating.
- If `clr_cnt` and an increment occur in the same cycle, the clear wins.
- Zero-length packets cannot occur, because TLAST is always carried on a data beat.

## Timing
- Reset values:
  - state `A_IDLE`;
  - `grant` 0;
  - `last_grant` N_CH-1, so channel 0 wins first;
  - all counters 0;
  - `M_AXIS_TVALID` 0, `M_AXIS_TLAST` 0, `M_AXIS_TDATA` 0;
  - all `S_AXIS_TREADY` 0.
- Latency and bubbles:
  - Data path latency is zero cycles (combinational mux).
  - Each packet costs exactly one idle arbitration cycle before its first beat, plus one tag cycle when tagging is compiled in.
- Reset mid-packet: the block returns to its reset state on the next edge. The partial packet stays with the upstream source; no recovery is attempted.
- `M_AXIS_TREADY` low stalls the granted channel only. Other channels back-pressure naturally.

## Configuration
- `VITA49_ARB_TAG_EN` defined:
  - `A_TAG` inserts one word before each packet: {8'hA5, 5'b0, grant padded to 3 bits, seq[grant]}.
  - During the tag word `M_AXIS_TVALID` is 1, `M_AXIS_TLAST` is 0, and all `S_AXIS_TREADY` are 0.
  - The block advances to `A_DATA` on the m_xfr of the tag word.
- Macro undefined: there is no `A_TAG` state and no tag word. The `seq` counters are still maintained, but they are unobservable.

## Structure
- Package `vita49_pkg` holds:
  - the state localparams (`A_IDLE`=2'd0, `A_TAG`=2'd1, `A_DATA`=2'd2);
  - `TAG_MAGIC`=8'hA5;
  - the ctrl bit indices (`CTRL_EN`, `CTRL_CLR`, `CTRL_MASK_LSB`).
- Sub-module `vita49_rr_pick`: a combinational round-robin picker.
  - Inputs: request vector and `last_grant`.
  - Outputs: `valid` and `idx`.

## Test plan
- **Single channel:** enable=1, mask=4'b0001, channel 0 sends 3 packets of 5 beats → 15 beats output; TLAST on beats 5, 10 and 15; pkt_fwd=3; beat_fwd=15.
- **Round robin:** all four channels hold packets continuously → grant order 0,1,2,3,0,…; each packet is contiguous; exactly one idle cycle between packets.
- **Back-pressure:** M_AXIS_TREADY toggles every cycle during a 10-beat packet on channel 2 → all 10 beats arrive in order; no other channel's TREADY is ever 1.
- **Mask / disable mid-packet:** drop enable on beat 3 of an 8-beat packet → all 8 beats complete; then the block sits in A_IDLE; pkt_fwd increments by 1.
- **Tag (VITA49_ARB_TAG_EN):** second packet from channel 1 → first output word is 32'hA5010001, followed by the payload.
- **Counter clear:** clr_cnt pulsed during a transfer on a cycle with an m_xfr → beat_fwd reads 0 on the next cycle and counts again from the following beat.

Source files
------------

// File: rtl/vita49_pkg.sv
// Shared definitions for the VITA-49 packet arbiter: FSM states, tag magic,
// control-register bit positions and a small round-robin index helper.
package vita49_pkg;

  typedef enum logic [1:0] {
    A_IDLE = 2'd0,
    A_TAG  = 2'd1,
    A_DATA = 2'd2
  } arb_state_e;

  localparam logic [7:0] TAG_MAGIC     = 8'hA5;
  localparam int         CTRL_EN       = 0;
  localparam int         CTRL_CLR      = 1;
  localparam int         CTRL_MASK_LSB = 8;

  // Reduce base (< 2*n) modulo n without a divider.
  function automatic int rr_wrap(input int base, input int n);
    return (base >= n) ? base - n : base;
  endfunction

endpackage

// File: rtl/vita49_rr_pick.sv
// Combinational round-robin picker: first active request searching upward
// from last_grant+1, wrapping modulo N_CH.
module vita49_rr_pick
  import vita49_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int GW   = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [GW-1:0]   last_grant,
  output logic            valid,
  output logic [GW-1:0]   idx
);

  // NOTE: every output gets a default before the loop so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    logic [GW-1:0] cand;
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    // Walk the farthest candidate first so the nearest one overwrites it.
    for (int i = N_CH; i >= 1; i--) begin
      cand = GW'(rr_wrap(int'(last_grant) + i, N_CH));
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/vita49_pkt_arb.sv
// Packet-granular round-robin AXI-Stream arbiter for up to eight VITA-49
// payload streams. Define VITA49_ARB_TAG_EN to prefix each packet with a tag word.
module vita49_pkt_arb
  import vita49_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int GW   = $clog2(N_CH)
) (
  input  logic                AXIS_ACLK,
  input  logic                AXIS_ARESETN,
  input  logic [N_CH*32-1:0]  S_AXIS_TDATA,
  input  logic [N_CH-1:0]     S_AXIS_TVALID,
  input  logic [N_CH-1:0]     S_AXIS_TLAST,
  output logic [N_CH-1:0]     S_AXIS_TREADY,
  output logic [31:0]         M_AXIS_TDATA,
  output logic                M_AXIS_TVALID,
  output logic                M_AXIS_TLAST,
  input  logic                M_AXIS_TREADY,
  input  logic [31:0]         ctrl,
  output logic [31:0]         status,
  output logic [31:0]         pkt_fwd,
  output logic [31:0]         beat_fwd
);

  arb_state_e      state;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   last_grant;
  logic [15:0]     seq [N_CH];

  logic            enable;
  logic            clr_cnt;
  logic [N_CH-1:0] ch_mask;
  logic            pick_valid;
  logic [GW-1:0]   pick_idx;
  logic            m_xfr;
  logic            pkt_done;
  logic            unused_ctrl;

  assign enable      = ctrl[CTRL_EN];
  assign clr_cnt     = ctrl[CTRL_CLR];
  assign ch_mask     = ctrl[CTRL_MASK_LSB +: N_CH];
  assign unused_ctrl = ^{ctrl[31:CTRL_MASK_LSB+N_CH], ctrl[CTRL_MASK_LSB-1:CTRL_CLR+1]};

  assign m_xfr    = M_AXIS_TVALID & M_AXIS_TREADY;
  assign pkt_done = (state == A_DATA) && m_xfr && M_AXIS_TLAST;

  vita49_rr_pick #(.N_CH(N_CH), .GW(GW)) u_pick (
    .req        (S_AXIS_TVALID & ch_mask),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .idx        (pick_idx)
  );

  // Zero-latency data path: the granted slave drives the master directly.
  always_comb begin
    M_AXIS_TDATA  = '0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TLAST  = 1'b0;
    S_AXIS_TREADY = '0;
    case (state)
`ifdef VITA49_ARB_TAG_EN
      A_TAG: begin
        M_AXIS_TDATA  = {TAG_MAGIC, 5'b0, 3'(grant), seq[grant]};
        M_AXIS_TVALID = 1'b1;
      end
`endif
      A_DATA: begin
        M_AXIS_TDATA         = S_AXIS_TDATA[32*grant +: 32];
        M_AXIS_TVALID        = S_AXIS_TVALID[grant];
        M_AXIS_TLAST         = S_AXIS_TLAST[grant];
        S_AXIS_TREADY[grant] = M_AXIS_TREADY;
      end
      default: ;
    endcase
  end

  assign status = {state, enable, 10'b0, 3'(last_grant), 5'b0, 3'(grant), 8'(S_AXIS_TVALID)};

  // NOTE: all state here uses <= so every register samples pre-edge values,
  // independent of statement order inside the block.
  always_ff @(posedge AXIS_ACLK) begin
    if (!AXIS_ARESETN) begin
      state      <= A_IDLE;
      grant      <= '0;
      last_grant <= GW'(N_CH - 1);
      pkt_fwd    <= '0;
      beat_fwd   <= '0;
      // NOTE: seq is a small register array, not a RAM, and its reset value is
      // visible in the tag word, so it is cleared like any other counter.
      for (int k = 0; k < N_CH; k++) seq[k] <= '0;
    end else begin
      case (state)
        A_IDLE: begin
          if (enable && pick_valid) begin
            grant <= pick_idx;
`ifdef VITA49_ARB_TAG_EN
            state <= A_TAG;
`else
            state <= A_DATA;
`endif
          end
        end
`ifdef VITA49_ARB_TAG_EN
        A_TAG: if (m_xfr) state <= A_DATA;
`endif
        A_DATA: begin
          if (pkt_done) begin
            last_grant <= grant;
            state      <= A_IDLE;
          end
        end
        default: state <= A_IDLE;
      endcase

      // Clear is a level and beats any increment in the same cycle.
      if (clr_cnt) begin
        pkt_fwd  <= '0;
        beat_fwd <= '0;
      end else if (state == A_DATA && m_xfr) begin
        beat_fwd <= beat_fwd + 32'd1;
        if (M_AXIS_TLAST) pkt_fwd <= pkt_fwd + 32'd1;
      end

      for (int k = 0; k < N_CH; k++) begin
        if (clr_cnt)                          seq[k] <= '0;
        else if (pkt_done && grant == GW'(k)) seq[k] <= seq[k] + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_vita49_pkt_arb.sv
// Self-checking bench for vita49_pkt_arb (N_CH=4): table-driven arbitration
// vectors plus directed multi-cycle sequences.
module tb_vita49_pkt_arb;
  import vita49_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] s_tdata;
  logic [3:0]   s_tvalid, s_tlast, s_tready;
  logic [31:0]  m_tdata;
  logic         m_tvalid, m_tlast, m_tready;
  logic [31:0]  ctrl, status, pkt_fwd, beat_fwd;

  int n_tests = 0;
  int n_fail  = 0;
  int tseq [4];
  int n_pkt;
  logic [1:0] g;

  always #5 clk = ~clk;

  vita49_pkt_arb #(.N_CH(4)) dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESETN  (rst_n),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TLAST  (s_tlast),
    .S_AXIS_TREADY (s_tready),
    .M_AXIS_TDATA  (m_tdata),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TLAST  (m_tlast),
    .M_AXIS_TREADY (m_tready),
    .ctrl          (ctrl),
    .status        (status),
    .pkt_fwd       (pkt_fwd),
    .beat_fwd      (beat_fwd)
  );

  typedef struct {
    logic [3:0] tv;
    logic [3:0] mask;
    bit         en;
    bit         exp_valid;
    logic [1:0] exp_grant;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ctl(input bit en, input bit clr, input logic [3:0] mask);
    return {16'b0, 4'b0, mask, 6'b0, clr, en};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    m_tready = 1'b0;
    ctrl     = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) tseq[c] = 0;
    check("rst_status", status, 32'h0003_0000);
    check("rst_pkt_fwd", pkt_fwd, 0);
    check("rst_beat_fwd", beat_fwd, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_s_tready", s_tready, 0);
  endtask

  // Active channels hold packets back to back; a scoreboard tracks the
  // expected round-robin owner, payload, TLAST position and idle gaps.
  task automatic run_stream(input logic [3:0] active, input int len, input int npkt,
                            input bit bp, input int drop_at);
    int b [4];
    int p [4];
    int cur = -1;
    int idle = 0;
    int lg_m = 3;
    int done = 0;
    int in_pkt = 0;
    int total;
    int hs_ch;
    bit others_bad = 0;
    total = npkt * $countones(active);
    for (int c = 0; c < 4; c++) begin b[c] = 0; p[c] = 0; end
    for (int cyc = 0; cyc < 2000 && done < total; cyc++) begin
      for (int c = 0; c < 4; c++) begin
        if (active[c] && p[c] < npkt) begin
          s_tvalid[c]         = 1'b1;
          s_tdata[32*c +: 32] = {8'(c), 8'(p[c]), 16'(b[c])};
          s_tlast[c]          = (b[c] == len - 1);
        end else begin
          s_tvalid[c] = 1'b0;
          s_tlast[c]  = 1'b0;
        end
      end
      m_tready = bp ? ~m_tready : 1'b1;
      #1;
      hs_ch = -1;
      if (!m_tvalid) idle++;
      else if (m_tready) begin
        for (int c = 0; c < 4; c++) if (s_tready[c] && s_tvalid[c]) hs_ch = c;
        if (cur < 0) begin
          for (int k = 4; k >= 1; k--) begin
            if (active[(lg_m + k) % 4] && p[(lg_m + k) % 4] < npkt) cur = (lg_m + k) % 4;
          end
          check("gap_idle", idle, 1);
        end
        if (hs_ch < 0) begin
`ifdef VITA49_ARB_TAG_EN
          check("tag_word", m_tdata, {8'hA5, 5'b0, 3'(cur), 16'(tseq[cur])});
`else
          check("orphan_beat", s_tready, 4'b1 << cur);
`endif
        end else begin
          check("beat_ch", hs_ch, cur);
          check("beat_data", m_tdata, {8'(cur), 8'(p[cur]), 16'(b[cur])});
          check("beat_last", m_tlast, (b[cur] == len - 1));
          in_pkt++;
          if (in_pkt == drop_at) ctrl[CTRL_EN] = 1'b0;
        end
      end
      if ((s_tready & ~((cur >= 0) ? (4'b1 << cur) : 4'b0)) != 4'b0) others_bad = 1'b1;
      @(posedge clk);
      if (hs_ch >= 0) begin
        if (b[hs_ch] == len - 1) begin
          b[hs_ch] = 0;
          p[hs_ch]++;
          tseq[hs_ch]++;
          lg_m   = hs_ch;
          done++;
          cur    = -1;
          idle   = 0;
          in_pkt = 0;
        end else begin
          b[hs_ch]++;
        end
      end
      @(negedge clk);
    end
    s_tvalid = '0;
    check("stream_done", done, total);
    check("others_tready", others_bad, 0);
  endtask

  initial begin
    tbl[0]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 2'd0};
    tbl[1]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 2'd1};
    tbl[2]  = '{4'b0001, 4'b1111, 1'b1, 1'b1, 2'd0};
    tbl[3]  = '{4'b1100, 4'b1111, 1'b1, 1'b1, 2'd2};
    tbl[4]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 2'd0};
    tbl[5]  = '{4'b1111, 4'b0101, 1'b1, 1'b1, 2'd0};
    tbl[6]  = '{4'b1010, 4'b1111, 1'b1, 1'b1, 2'd1};
    tbl[7]  = '{4'b1010, 4'b1111, 1'b1, 1'b1, 2'd3};
    tbl[8]  = '{4'b0110, 4'b0011, 1'b1, 1'b1, 2'd1};
    tbl[9]  = '{4'b0000, 4'b1111, 1'b1, 1'b0, 2'd0};
    tbl[10] = '{4'b1111, 4'b1000, 1'b1, 1'b1, 2'd3};
    tbl[11] = '{4'b1111, 4'b1111, 1'b1, 1'b1, 2'd0};
    tbl[12] = '{4'b1111, 4'b1111, 1'b0, 1'b0, 2'd0};

    // Table: one-beat packets, one arbitration decision per record.
    do_reset();
    n_pkt = 0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      ctrl     = ctl(tbl[i].en, 1'b0, tbl[i].mask);
      s_tvalid = tbl[i].tv;
      s_tlast  = 4'hF;
      m_tready = 1'b0;
      for (int c = 0; c < 4; c++) s_tdata[32*c +: 32] = 32'hD000_0000 | (i << 8) | c;
      #1;
      check("idle_s_tready", s_tready, 0);
      check("idle_m_tvalid", m_tvalid, 0);
      check("tbl_status_en", status[29], tbl[i].en);
      @(negedge clk);
      if (tbl[i].exp_valid) begin
        g = tbl[i].exp_grant;
`ifdef VITA49_ARB_TAG_EN
        check("tbl_tag_state", status[31:30], A_TAG);
        check("tbl_tag_word", m_tdata, {8'hA5, 5'b0, 3'(g), 16'(tseq[g])});
        m_tready = 1'b1;
        @(negedge clk);
        m_tready = 1'b0;
`endif
        check("tbl_state", status[31:30], 2);
        check("tbl_grant", status[10:8], g);
        check("tbl_tdata", m_tdata, 32'hD000_0000 | (i << 8) | g);
        check("tbl_tlast", m_tlast, 1);
        check("tbl_tready_stall", s_tready, 0);
        m_tready = 1'b1;
        #1;
        check("tbl_tready", s_tready, 4'b1 << g);
        @(negedge clk);
        m_tready = 1'b0;
        s_tvalid = '0;
        check("tbl_last_grant", status[18:16], g);
        check("tbl_back_idle", status[31:30], 0);
        n_pkt++;
        tseq[g]++;
      end else begin
        check("tbl_no_grant_state", status[31:30], 0);
        check("tbl_no_grant_tvalid", m_tvalid, 0);
      end
    end
    check("tbl_pkt_fwd", pkt_fwd, n_pkt);
    check("tbl_beat_fwd", beat_fwd, n_pkt);

    // Single channel: 3 packets of 5 beats on channel 0.
    do_reset();
    ctrl = ctl(1'b1, 1'b0, 4'b0001);
    run_stream(4'b0001, 5, 3, 1'b0, 0);
    check("single_pkt_fwd", pkt_fwd, 3);
    check("single_beat_fwd", beat_fwd, 15);

    // Round robin: all four channels busy, two 3-beat packets each.
    do_reset();
    ctrl = ctl(1'b1, 1'b0, 4'b1111);
    run_stream(4'b1111, 3, 2, 1'b0, 0);
    check("rr_pkt_fwd", pkt_fwd, 8);
    check("rr_beat_fwd", beat_fwd, 24);
    check("rr_last_grant", status[18:16], 3);

    // Back-pressure: toggling downstream ready on a 10-beat packet, channel 2.
    do_reset();
    ctrl = ctl(1'b1, 1'b0, 4'b0100);
    run_stream(4'b0100, 10, 1, 1'b1, 0);
    check("bp_pkt_fwd", pkt_fwd, 1);
    check("bp_beat_fwd", beat_fwd, 10);

    // Disable during beat 3 of an 8-beat packet: packet completes, then idle.
    do_reset();
    ctrl = ctl(1'b1, 1'b0, 4'b0001);
    run_stream(4'b0001, 8, 1, 1'b0, 3);
    check("dis_pkt_fwd", pkt_fwd, 1);
    check("dis_beat_fwd", beat_fwd, 8);
    s_tvalid = 4'b0001;
    s_tlast  = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("dis_hold_state", status[31:30], 0);
      check("dis_hold_tvalid", m_tvalid, 0);
    end
    s_tvalid = '0;

    // Counter clear on a cycle with a transfer: clear wins, then counts resume.
    do_reset();
    @(negedge clk);
    ctrl     = ctl(1'b1, 1'b0, 4'b0001);
    m_tready = 1'b1;
    s_tvalid = 4'b0001;
    s_tlast  = 4'b0000;
    s_tdata[31:0] = 32'h100;
    @(negedge clk);
`ifdef VITA49_ARB_TAG_EN
    @(negedge clk);
`endif
    check("clr_start", beat_fwd, 0);
    @(negedge clk);
    s_tdata[31:0] = 32'h101;
    @(negedge clk);
    check("clr_before", beat_fwd, 2);
    s_tdata[31:0] = 32'h102;
    ctrl = ctl(1'b1, 1'b1, 4'b0001);
    @(negedge clk);
    check("clr_wins", beat_fwd, 0);
    check("clr_pkt", pkt_fwd, 0);
    ctrl = ctl(1'b1, 1'b0, 4'b0001);
    s_tdata[31:0] = 32'h103;
    s_tlast = 4'b0001;
    @(negedge clk);
    s_tvalid = '0;
    check("clr_resume", beat_fwd, 1);
    check("clr_resume_pkt", pkt_fwd, 1);
    check("clr_idle", status[31:30], 0);

`ifdef VITA49_ARB_TAG_EN
    // Tag: second packet from channel 1 starts with 32'hA5010001.
    do_reset();
    ctrl = ctl(1'b1, 1'b0, 4'b0010);
    run_stream(4'b0010, 2, 1, 1'b0, 0);
    s_tvalid = 4'b0010;
    s_tlast  = 4'b0000;
    s_tdata[63:32] = 32'h0000_BEEF;
    m_tready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("tag_second_pkt", m_tdata, 32'hA501_0001);
    check("tag_tlast", m_tlast, 0);
    check("tag_s_tready", s_tready, 0);
    m_tready = 1'b1;
    @(negedge clk);
    check("tag_then_payload", m_tdata, 32'h0000_BEEF);
`endif

    // Reset mid-packet returns the block to its reset state.
    @(negedge clk);
    ctrl     = ctl(1'b1, 1'b0, 4'b0001);
    s_tvalid = 4'b0001;
    s_tlast  = 4'b0000;
    m_tready = 1'b1;
    repeat (3) @(negedge clk);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
